// File: rtl/div_result_fifo.sv
// -----------------------------------------------------------------------------
// div_result_fifo
//
// Purpose:
//   Buffers quotient/remainder results from the unsigned divider. The divider
//   presents each result as a single-cycle pulse and cannot be stalled, so
//   results are captured into a small FIFO. The FIFO re-presents them to the
//   consumer on a first-word-fall-through ready/valid interface. It also feeds
//   an almost-full flag back to the producer. Any result that arrives with no
//   room left is dropped and flagged stickily.
//
// Optional feature:
//   Define DIV_RESULT_FIFO_DIVZERO_EN to add o_divzero. This is a per-entry
//   flag for the divider's divide-by-zero signature (quotient and remainder
//   both all-ones). It is stored as a 65th bit of each entry.
//
// Parameters:
//   DEPTH        number of result entries (power of 2, >= 2)
//   AFULL_LEVEL  o_almost_full asserts when occupancy >= AFULL_LEVEL (1..DEPTH)
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous active-high reset
//   i_valid         divider result valid (single-cycle pulse, no ready)
//   i_payload_1     quotient from divider
//   i_payload_2     remainder from divider
//   o_almost_full   occupancy >= AFULL_LEVEL
//   o_ready         consumer ready
//   o_valid         FIFO non-empty, head entry presented
//   o_payload_1     head quotient (0 while empty)
//   o_payload_2     head remainder (0 while empty)
//   o_count         current occupancy, 0..DEPTH
//   o_overflow      sticky: a result was dropped
//   i_overflow_clr  clears o_overflow (a drop in the same cycle wins)
//   o_divzero       head entry is a divide-by-zero result (optional)
// -----------------------------------------------------------------------------
module div_result_fifo #(
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [31:0]              i_payload_1,
  input  logic [31:0]              i_payload_2,
  output logic                     o_almost_full,
  input  logic                     o_ready,
  output logic                     o_valid,
  output logic [31:0]              o_payload_1,
  output logic [31:0]              o_payload_2,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  input  logic                     i_overflow_clr
`ifdef DIV_RESULT_FIFO_DIVZERO_EN
  ,
  output logic                     o_divzero
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef DIV_RESULT_FIFO_DIVZERO_EN
  localparam int WIDTH = 65;
`else
  localparam int WIDTH = 64;
`endif

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [WIDTH-1:0] w_entry;
  logic [WIDTH-1:0] w_head;

  // Full and empty are told apart by the occupancy counter. The pointers
  // alone are equal in both states.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = o_valid && o_ready;
  // When full, a push is still accepted if the same edge pops, because the
  // pop frees the slot being written.
  assign w_push = i_valid && (!w_full || w_pop);
  assign w_drop = i_valid && w_full && !w_pop;

`ifdef DIV_RESULT_FIFO_DIVZERO_EN
  // All-ones quotient and remainder cannot occur for a nonzero divisor.
  assign w_entry = {(&{i_payload_1, i_payload_2}), i_payload_1, i_payload_2};
`else
  assign w_entry = {i_payload_1, i_payload_2};
`endif

  assign w_head = r_mem[r_rd_ptr];

  // Storage array write port. The contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag. A drop outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_overflow_clr) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Status outputs are decoded from the count register.
  // The head payload falls through from the array and is masked while empty.
  always_comb begin
    o_valid       = (r_count != {CW{1'b0}});
    o_almost_full = (r_count >= CW'(AFULL_LEVEL));
    o_count       = r_count;
    o_overflow    = r_overflow;
    if (o_valid) begin
      o_payload_1 = w_head[63:32];
      o_payload_2 = w_head[31:0];
    end else begin
      o_payload_1 = 32'd0;
      o_payload_2 = 32'd0;
    end
`ifdef DIV_RESULT_FIFO_DIVZERO_EN
    o_divzero = o_valid && w_head[64];
`endif
  end

endmodule

// File: tb/tb_div_result_fifo.sv
module tb_div_result_fifo;

  localparam int DEPTH = 8;
  localparam int AFULL = 6;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic [31:0]   i_payload_1;
  logic [31:0]   i_payload_2;
  logic          o_almost_full;
  logic          o_ready;
  logic          o_valid;
  logic [31:0]   o_payload_1;
  logic [31:0]   o_payload_2;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic          i_overflow_clr;
`ifdef DIV_RESULT_FIFO_DIVZERO_EN
  logic          o_divzero;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {quotient, remainder} plus the sticky flag.
  logic [63:0] mq[$];
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  div_result_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_valid        (i_valid),
    .i_payload_1    (i_payload_1),
    .i_payload_2    (i_payload_2),
    .o_almost_full  (o_almost_full),
    .o_ready        (o_ready),
    .o_valid        (o_valid),
    .o_payload_1    (o_payload_1),
    .o_payload_2    (o_payload_2),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .i_overflow_clr (i_overflow_clr)
`ifdef DIV_RESULT_FIFO_DIVZERO_EN
    ,
    .o_divzero      (o_divzero)
`endif
  );

  typedef struct {
    logic        v;
    logic [31:0] q;
    logic [31:0] r;
    logic        rdy;
    logic        clr;
    int          exp_count;
    logic        exp_valid;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all DUT outputs against the reference model.
  task automatic check_model();
    logic [63:0] head;
    head = (mq.size() != 0) ? mq[0] : 64'd0;
    chk("count", 64'(o_count), 64'(mq.size()));
    chk("valid", 64'(o_valid), 64'(mq.size() != 0));
    chk("almost_full", 64'(o_almost_full), 64'(mq.size() >= AFULL));
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
    chk("payload", {o_payload_1, o_payload_2}, head);
`ifdef DIV_RESULT_FIFO_DIVZERO_EN
    chk("divzero", 64'(o_divzero), 64'(head == 64'hFFFFFFFF_FFFFFFFF));
`endif
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input logic v, input logic [31:0] q, input logic [31:0] r,
                      input logic rdy, input logic clr, input logic rst);
    logic pop, push, drop;
    reset          = rst;
    i_valid        = v;
    i_payload_1    = q;
    i_payload_2    = r;
    o_ready        = rdy;
    i_overflow_clr = clr;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      push = v && ((mq.size() < DEPTH) || pop);
      drop = v && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({q, r});
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] rq, rr;
    reset = 1'b1; i_valid = 1'b0; i_payload_1 = 32'd0; i_payload_2 = 32'd0;
    o_ready = 1'b0; i_overflow_clr = 1'b0;

    // Reset state
    step(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_count", 64'(o_count), 64'd0);

    // Table-driven basic sequence
    vecs[0] = '{1'b1, 32'd3, 32'd2,  1'b1, 1'b0, 1, 1'b1, 32'd3, 32'd2,  1'b0};
    vecs[1] = '{1'b0, 32'd0, 32'd0,  1'b1, 1'b0, 0, 1'b0, 32'd0, 32'd0,  1'b0};
    vecs[2] = '{1'b1, 32'd5, 32'd6,  1'b0, 1'b0, 1, 1'b1, 32'd5, 32'd6,  1'b0};
    vecs[3] = '{1'b1, 32'd7, 32'd8,  1'b0, 1'b0, 2, 1'b1, 32'd5, 32'd6,  1'b0};
    vecs[4] = '{1'b1, 32'd9, 32'd10, 1'b1, 1'b0, 2, 1'b1, 32'd7, 32'd8,  1'b0};
    vecs[5] = '{1'b0, 32'd0, 32'd0,  1'b1, 1'b0, 1, 1'b1, 32'd9, 32'd10, 1'b0};
    vecs[6] = '{1'b0, 32'd0, 32'd0,  1'b1, 1'b0, 0, 1'b0, 32'd0, 32'd0,  1'b0};
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].v, vecs[i].q, vecs[i].r, vecs[i].rdy, vecs[i].clr, 1'b0);
      chk("vec_count", 64'(o_count), 64'(vecs[i].exp_count));
      chk("vec_valid", 64'(o_valid), 64'(vecs[i].exp_valid));
      chk("vec_payload", {o_payload_1, o_payload_2}, {vecs[i].exp_q, vecs[i].exp_r});
      chk("vec_overflow", 64'(o_overflow), 64'(vecs[i].exp_ovf));
    end

    // Fill 8 with no consumer; almost-full rises after the 6th push
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 32'(k), 32'(k + 100), 1'b0, 1'b0, 1'b0);
      chk("fill_afull", 64'(o_almost_full), 64'(k >= 5));
    end
    chk("fill_count", 64'(o_count), 64'd8);
    chk("fill_head", 64'(o_payload_1), 64'd0);

    // 9th push is dropped
    step(1'b1, 32'd99, 32'd199, 1'b0, 1'b0, 1'b0);
    chk("drop_ovf", 64'(o_overflow), 64'd1);
    chk("drop_count", 64'(o_count), 64'd8);
    // Clear with no drop
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", 64'(o_overflow), 64'd0);

    // Full: push and pop in the same cycle
    step(1'b1, 32'd55, 32'd155, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count", 64'(o_count), 64'd8);
    chk("fullpp_ovf", 64'(o_overflow), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 64'(o_payload_1), (i < 7) ? 64'(i + 1) : 64'd55);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", 64'(o_valid), 64'd0);

    // Refill, then drop and clear in the same cycle: the set wins
    for (int k = 0; k < 8; k++) step(1'b1, 32'(k + 200), 32'(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd77, 32'd77, 1'b0, 1'b1, 1'b0);
    chk("drop_clr_ovf", 64'(o_overflow), 64'd1);
    // Pop down to 5 entries, then reset (with a push in the reset cycle)
    for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_count", 64'(o_count), 64'd5);
    step(1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    chk("midreset_valid", 64'(o_valid), 64'd0);
    chk("midreset_count", 64'(o_count), 64'd0);
    chk("midreset_ovf", 64'(o_overflow), 64'd0);

`ifdef DIV_RESULT_FIFO_DIVZERO_EN
    step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("divzero_first", 64'(o_divzero), 64'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("divzero_second", 64'(o_divzero), 64'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
`endif

    // Randomized traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      rq = $urandom;
      rr = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        rq = 32'hFFFFFFFF;
        rr = 32'hFFFFFFFF;
      end
      step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, rq, rr,
           ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
